// File: rtl/float_pkg.sv
// Shared half-precision constants, FSM state type and helpers
// for the iterative FP subtractor.
package float_pkg;

  localparam int FW   = 16;
  localparam int MW   = 10;
  localparam int EW   = 5;
  localparam int BIAS = 15;
  localparam int GRS  = 3;
  localparam int SW   = MW + 1 + GRS;

  localparam logic [5:0] EXP_INF = 6'(2 * BIAS + 1);

  localparam logic [FW-1:0] QNAN = 16'h7E00;
  localparam logic [FW-1:0] PINF = 16'h7C00;
  localparam logic [FW-1:0] NINF = 16'hFC00;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_ROUND,
    S_DONE
  } state_t;

  function automatic logic [FW-1:0] inf_of(input logic s);
    return s ? NINF : PINF;
  endfunction

endpackage

// File: rtl/float_unpack.sv
// Combinational half-precision classifier: sign, effective
// exponent, significand with hidden bit, and operand class.
module float_unpack
  import float_pkg::*;
(
  input  logic [FW-1:0] f_i,
  output logic          sign_o,
  output logic [EW-1:0] exp_o,
  output logic [MW:0]   sig_o,
  output logic          is_zero_o,
  output logic          is_sub_o,
  output logic          is_inf_o,
  output logic          is_nan_o
);

  logic [EW-1:0] e;
  logic [MW-1:0] m;
  logic          e_zero;
  logic          e_max;
  logic          m_zero;

  assign e      = f_i[FW-2:MW];
  assign m      = f_i[MW-1:0];
  assign e_zero = (e == '0);
  assign e_max  = &e;
  assign m_zero = (m == '0);

  // Subnormals share exponent 1 with the smallest normals.
  assign sign_o    = f_i[FW-1];
  assign exp_o     = e_zero ? EW'(1) : e;
  assign sig_o     = {~e_zero, m};
  assign is_zero_o = e_zero & m_zero;
  assign is_sub_o  = e_zero & ~m_zero;
  assign is_inf_o  = e_max & m_zero;
  assign is_nan_o  = e_max & ~m_zero;

endmodule

// File: rtl/float_sub_iter.sv
// Iterative half-precision subtractor: one alignment or
// normalization bit per cycle behind a valid/ready handshake.
module float_sub_iter
  import float_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [FW-1:0] float_a,
  input  logic [FW-1:0] float_b,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [FW-1:0] res
);

  logic          a_s, a_z, a_sub, a_inf, a_nan;
  logic          b_s, b_z, b_sub, b_inf, b_nan;
  logic [EW-1:0] a_e, b_e;
  logic [MW:0]   a_m, b_m;
  logic          unused_cls;

  float_unpack u_unpack_a (
    .f_i       (float_a),
    .sign_o    (a_s),
    .exp_o     (a_e),
    .sig_o     (a_m),
    .is_zero_o (a_z),
    .is_sub_o  (a_sub),
    .is_inf_o  (a_inf),
    .is_nan_o  (a_nan)
  );

  float_unpack u_unpack_b (
    .f_i       ({~float_b[FW-1], float_b[FW-2:0]}),
    .sign_o    (b_s),
    .exp_o     (b_e),
    .sig_o     (b_m),
    .is_zero_o (b_z),
    .is_sub_o  (b_sub),
    .is_inf_o  (b_inf),
    .is_nan_o  (b_nan)
  );

  assign unused_cls = a_z ^ a_sub ^ b_z ^ b_sub;

  state_t          state_q, state_d;
  logic            sign_q, sign_d;
  logic            sub_q, sub_d;
  logic [5:0]      exp_q, exp_d;
  logic [SW-1:0]   man_q, man_d;
  logic [SW-1:0]   sm_q, sm_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [FW-1:0]   res_q, res_d;

  logic            a_ge;
  logic [EW-1:0]   e_big, e_sm, diff;
  logic [MW:0]     m_big, m_sm;
  logic [3:0]      shamt;
  logic            special;
  logic [FW-1:0]   spec_res;

  assign a_ge  = {a_e, a_m} >= {b_e, b_m};
  assign e_big = a_ge ? a_e : b_e;
  assign e_sm  = a_ge ? b_e : a_e;
  assign m_big = a_ge ? a_m : b_m;
  assign m_sm  = a_ge ? b_m : a_m;
  assign diff  = e_big - e_sm;
  assign shamt = (diff > 5'd13) ? 4'd13 : diff[3:0];

  assign special = a_nan | b_nan | a_inf | b_inf;

  always_comb begin
    spec_res = QNAN;
    if (a_nan || b_nan)
      spec_res = QNAN;
    else if (a_inf && b_inf)
      spec_res = (a_s == b_s) ? inf_of(a_s) : QNAN;
    else if (a_inf)
      spec_res = inf_of(a_s);
    else
      spec_res = inf_of(b_s);
  end

  logic [SW:0]   sum_w;
  logic [SW-1:0] add_man, norm_man;
  logic [5:0]    add_exp, norm_exp;

  assign sum_w = sub_q ? ({1'b0, man_q} - {1'b0, sm_q})
                       : ({1'b0, man_q} + {1'b0, sm_q});
  assign add_man = sum_w[SW]
                 ? {sum_w[SW:2], sum_w[1] | sum_w[0]}
                 : sum_w[SW-1:0];
  assign add_exp  = exp_q + {5'd0, sum_w[SW]};
  assign norm_man = {man_q[SW-2:0], 1'b0};
  assign norm_exp = exp_q - 6'd1;

  // Round-to-nearest-even on the low G/R/S bits.
  logic          up;
  logic [MW+1:0] rsig;
  logic [5:0]    r_exp;
  logic [MW-1:0] r_frac;
  logic          r_hid;
  logic [FW-1:0] rnd_res;

  assign up     = man_q[2] & (man_q[1] | man_q[0] | man_q[3]);
  assign rsig   = {1'b0, man_q[SW-1:GRS]} + {11'd0, up};
  assign r_exp  = exp_q + {5'd0, rsig[MW+1]};
  assign r_frac = rsig[MW+1] ? rsig[MW:1] : rsig[MW-1:0];
  assign r_hid  = rsig[MW+1] | rsig[MW];

  always_comb begin
    rnd_res = '0;
    if (man_q == '0)
      rnd_res = sub_q ? '0 : {sign_q, 15'd0};
    else if (r_exp >= EXP_INF)
      rnd_res = inf_of(sign_q);
    else
      rnd_res = {sign_q, r_hid ? r_exp[EW-1:0] : 5'd0, r_frac};
  end

  function automatic logic need_norm(
    input logic [SW-1:0] m,
    input logic [5:0]    e
  );
    return (m != '0) && !m[SW-1] && (e > 6'd1);
  endfunction

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    sub_d   = sub_q;
    exp_d   = exp_q;
    man_d   = man_q;
    sm_d    = sm_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          sign_d = a_ge ? a_s : b_s;
          sub_d  = a_s ^ b_s;
          exp_d  = {1'b0, e_big};
          man_d  = {m_big, 3'b000};
          sm_d   = {m_sm, 3'b000};
          cnt_d  = shamt;
          if (special) begin
            res_d   = spec_res;
            state_d = S_DONE;
          end else begin
            state_d = (shamt != 4'd0) ? S_ALIGN : S_ADD;
          end
        end
      end
      S_ALIGN: begin
        sm_d  = {1'b0, sm_q[SW-1:2], sm_q[1] | sm_q[0]};
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1)
          state_d = S_ADD;
      end
      S_ADD: begin
        man_d   = add_man;
        exp_d   = add_exp;
        state_d = need_norm(add_man, add_exp) ? S_NORM : S_ROUND;
      end
      S_NORM: begin
        man_d   = norm_man;
        exp_d   = norm_exp;
        state_d = need_norm(norm_man, norm_exp) ? S_NORM : S_ROUND;
      end
      S_ROUND: begin
        res_d   = rnd_res;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sign_q  <= 1'b0;
      sub_q   <= 1'b0;
      exp_q   <= '0;
      man_q   <= '0;
      sm_q    <= '0;
      cnt_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      sub_q   <= sub_d;
      exp_q   <= exp_d;
      man_q   <= man_d;
      sm_q    <= sm_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign res       = res_q;

endmodule

// File: tb/tb_float_sub_iter.sv
// Randomized self-checking bench for float_sub_iter against an
// exact-integer half-precision subtraction model.
module tb_float_sub_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] float_a;
  logic [15:0] float_b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] res;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  float_sub_iter dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .float_a   (float_a),
    .float_b   (float_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit is_nan(input logic [15:0] x);
    return (x[14:10] == 5'h1F) && (x[9:0] != 10'd0);
  endfunction

  function automatic bit is_inf(input logic [15:0] x);
    return x[14:0] == 15'h7C00;
  endfunction

  // Magnitude in units of 2^-24.
  function automatic longint mag(input logic [15:0] x);
    longint m;
    m = longint'(x[9:0]);
    if (x[14:10] != 5'd0)
      m = (m + 1024) << (x[14:10] - 5'd1);
    return m;
  endfunction

  function automatic int msb(input longint n);
    for (int i = 62; i >= 0; i--)
      if (n[i]) return i;
    return -1;
  endfunction

  function automatic longint exact_diff(input logic [15:0] a,
                                        input logic [15:0] b);
    longint va, vb;
    va = a[15] ? -mag(a) : mag(a);
    vb = b[15] ? -mag(b) : mag(b);
    return va - vb;
  endfunction

  function automatic logic [15:0] round_enc(input logic s,
                                            input longint n);
    int          p, sh, e;
    longint      q, rem, half;
    logic [14:0] t;
    logic [4:0]  ef;
    logic [9:0]  fr;
    if (n < 2048) begin
      t = n[14:0];
      return {s, t};
    end
    p    = msb(n);
    sh   = p - 10;
    q    = n >> sh;
    rem  = n - (q << sh);
    half = longint'(1) << (sh - 1);
    if (rem > half || (rem == half && q[0]))
      q++;
    if (q == 2048) begin
      q = 1024;
      sh++;
    end
    e = sh + 1;
    if (e >= 31)
      return {s, 15'h7C00};
    ef = e[4:0];
    fr = q[9:0];
    return {s, ef, fr};
  endfunction

  function automatic logic [15:0] model(input logic [15:0] a,
                                       input logic [15:0] b);
    logic   sa, sb;
    longint d;
    sa = a[15];
    sb = ~b[15];
    if (is_nan(a) || is_nan(b)) return 16'h7E00;
    if (is_inf(a) && is_inf(b))
      return (sa == sb) ? {sa, 15'h7C00} : 16'h7E00;
    if (is_inf(a)) return {sa, 15'h7C00};
    if (is_inf(b)) return {sb, 15'h7C00};
    d = exact_diff(a, b);
    if (d == 0)
      return (sa == sb) ? {sa, 15'd0} : 16'h0000;
    return round_enc(d < 0, (d < 0) ? -d : d);
  endfunction

  function automatic int model_lat(input logic [15:0] a,
                                   input logic [15:0] b);
    int     ea, eb, d, ebig, epre, norm, p;
    longint n;
    if (is_nan(a) || is_nan(b) || is_inf(a) || is_inf(b))
      return 1;
    ea   = (a[14:10] == 5'd0) ? 1 : int'(a[14:10]);
    eb   = (b[14:10] == 5'd0) ? 1 : int'(b[14:10]);
    d    = (ea > eb) ? ea - eb : eb - ea;
    ebig = (ea > eb) ? ea : eb;
    n    = exact_diff(a, b);
    if (n < 0) n = -n;
    norm = 0;
    if (n != 0) begin
      p    = msb(n);
      epre = (p >= 10) ? p - 9 : 1;
      norm = (ebig > epre) ? ebig - epre : 0;
    end
    return 3 + ((d > 13) ? 13 : d) + norm;
  endfunction

  // ---------------- per-cycle stability monitor ----------------
  logic        hold_q = 1'b0;
  logic [15:0] hold_res_q = 16'h0;

  always @(posedge clk) begin
    hold_q     <= out_valid && !out_ready && !rst;
    hold_res_q <= res;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (hold_q) begin
        check("stall_valid", out_valid, 1);
        check("stall_res", res, hold_res_q);
      end
      if (in_ready && out_valid)
        check("ready_valid_excl", 1, 0);
    end
  end

  // ---------------- driver / result checker ----------------
  task automatic run_op(input logic [15:0] a,
                        input logic [15:0] b,
                        input int          hold,
                        input bit          pin,
                        input logic [15:0] pin_res,
                        input int          pin_lat);
    logic [15:0] exp_r;
    int          exp_l, lat, k;
    exp_r = model(a, b);
    exp_l = model_lat(a, b);
    if (pin) begin
      check("model_pin_res", exp_r, pin_res);
      check("model_pin_lat", exp_l, pin_lat);
    end
    out_ready = (hold == 0);
    float_a   = a;
    float_b   = b;
    in_valid  = 1'b1;
    k = 0;
    while (!in_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
    float_a  = 16'($urandom);
    float_b  = 16'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("res", res, exp_r);
    check("latency", lat, exp_l);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        float_a  = 16'($urandom);
        float_b  = 16'($urandom);
        @(negedge clk);
        check("bp_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("post_valid", out_valid, 0);
    check("post_ready", in_ready, 1);
    check("post_res", res, exp_r);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    logic [15:0] ra, rb;
    int          hold;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    float_a   = 16'h0;
    float_b   = 16'h0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_res", res, 16'h0000);
    rst = 1'b0;
    @(negedge clk);

    run_op(16'h34CD, 16'h3266, 0, 1, 16'h2E68, 6);
    run_op(16'h34CD, 16'h34CD, 0, 1, 16'h0000, 3);
    run_op(16'h6108, 16'hE108, 0, 1, 16'h6508, 3);
    run_op(16'h3C00, 16'h0C00, 0, 1, 16'h3C00, 16);
    run_op(16'h3C00, 16'h1000, 0, 1, 16'h3BFF, 15);
    run_op(16'h7C00, 16'h7C00, 0, 1, 16'h7E00, 1);
    run_op(16'h7C00, 16'hFC00, 0, 1, 16'h7C00, 1);
    run_op(16'h7BFF, 16'hFBFF, 0, 1, 16'h7C00, 3);
    run_op(16'h7E01, 16'h3C00, 0, 1, 16'h7E00, 1);
    run_op(16'h3C00, 16'hFD00, 0, 1, 16'h7E00, 1);
    run_op(16'h8000, 16'h0000, 0, 1, 16'h8000, 3);
    run_op(16'h0001, 16'h0002, 0, 1, 16'h8001, 3);
    run_op(16'h34CD, 16'h3266, 5, 1, 16'h2E68, 6);

    // Reset in the middle of a long alignment.
    out_ready = 1'b1;
    float_a   = 16'h3C00;
    float_b   = 16'h0C00;
    in_valid  = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_valid", out_valid, 0);
    check("midrst_res", res, 16'h0000);
    check("midrst_ready", in_ready, 1);
    rst = 1'b0;
    run_op(16'h3C00, 16'h1000, 0, 1, 16'h3BFF, 15);

    for (int i = 0; i < 400; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if ($urandom_range(0, 1) == 0) begin
        rb[14:10] = ra[14:10] ^ 5'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0)
          rb[9:0] = ra[9:0] ^ 10'($urandom_range(0, 7));
      end
      hold = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      run_op(ra, rb, hold, 0, 16'h0, 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
